// File: rtl/lane_array_fifo.sv
// lane_array_fifo: show-ahead valid/ready FIFO for channel x lane x bit packed words,
// with optional per-channel lane reversal on write and a 64-bit delivered-word counter.
module lane_array_fifo #(
  parameter int unsigned CH    = 2,
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CH-1:0][LANES-1:0][W-1:0]    in_data,
  input  logic                               in_rev,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CH-1:0][LANES-1:0][W-1:0]    out_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic [63:0]                        xfer_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef logic [CH-1:0][LANES-1:0][W-1:0] word_t;

  word_t         mem_q [DEPTH];
  word_t         wr_word;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   xfer_cnt_q, xfer_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          wr_fire, rd_fire;

  // Handshake decode; flush discards any transfer in the same cycle.
  always_comb begin
    in_ready  = !rst && (count_q < DepthC);
    out_valid = out_valid_q;
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    xfer_cnt  = xfer_cnt_q;
    wr_fire   = in_valid && in_ready && !flush;
    rd_fire   = out_valid_q && out_ready && !flush;
  end

  // Optional lane reversal inside every channel; channel order is kept.
  always_comb begin
    wr_word = in_data;
    if (in_rev) begin
      for (int c = 0; c < int'(CH); c++) begin
        for (int l = 0; l < int'(LANES); l++) begin
          wr_word[c][l] = in_data[c][int'(LANES) - 1 - l];
        end
      end
    end
  end

  // Next-state for pointers, occupancy, valid flag and delivered-word counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        xfer_cnt_d = xfer_cnt_q + 64'd1;
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    out_valid_d = (count_d != '0);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      xfer_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      xfer_cnt_q  <= xfer_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_word;
  end

endmodule

// File: tb/tb_lane_array_fifo.sv
// Directed self-checking bench for lane_array_fifo at default shape (2x4x4, depth 4).
module tb_lane_array_fifo;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0][3:0][3:0] in_data;
  logic                 in_rev;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0][3:0][3:0] out_data;
  logic [2:0]           count;
  logic [63:0]          xfer_cnt;

  int n_cmp;
  int n_bad;

  lane_array_fifo #(
    .CH   (2),
    .LANES(4),
    .W    (4),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rev   (in_rev),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_data"}, 64'(out_data), 64'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [31:0] fill_w [4];
  logic [31:0] model_q [$];
  logic [15:0] pat_in;
  logic [15:0] pat_out;
  int          sent;
  int          got;
  bit          wf;
  bit          rf;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rev    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fill_w[0] = 32'h1234_5678;
    fill_w[1] = 32'h9ABC_DEF0;
    fill_w[2] = 32'h0F0F_0F0F;
    fill_w[3] = 32'hFFFF_0000;
    pat_in    = 16'b1011_0111_1101_1110;
    pat_out   = 16'b0110_1100_1011_0011;

    // Reset state
    step();
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_xfer", xfer_cnt, 64'd0);
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Fill to full; a fifth word must be refused
    for (int i = 0; i < 4; i++) push(fill_w[i]);
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    check_eq("full_head", 64'(out_data), 64'h1234_5678);
    push(32'hDEAD_BEEF);
    check_eq("full_count_after_5th", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) pop_check("fill_drain", fill_w[i]);
    check_eq("drain_count", 64'(count), 64'd0);
    check_eq("drain_valid", 64'(out_valid), 64'd0);
    check_eq("drain_xfer", xfer_cnt, 64'd4);

    // Lane reversal on write, then an unreversed word
    in_rev = 1'b1;
    check_eq("latency_pre", 64'(out_valid), 64'd0);
    push(32'h1234_5678);
    in_rev = 1'b0;
    check_eq("latency_post", 64'(out_valid), 64'd1);
    push(32'hCAFE_BABE);
    pop_check("rev", 32'h4321_8765);
    pop_check("norev", 32'hCAFE_BABE);
    check_eq("rev_xfer", xfer_cnt, 64'd6);

    // Simultaneous read and write at count=2
    push(32'h1000_0000);
    push(32'h1000_0001);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h1000_0002 + 32'(i);
      out_ready = 1'b1;
      check_eq("rw_count", 64'(count), 64'd2);
      check_eq("rw_head", 64'(out_data), 64'(32'h1000_0000 + 32'(i)));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("rw_count_end", 64'(count), 64'd2);
    check_eq("rw_xfer", xfer_cnt, 64'd16);
    pop_check("rw_tail0", 32'h1000_000A);
    pop_check("rw_tail1", 32'h1000_000B);

    // Nine words across pointer wrap with fixed stall patterns
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 9; cyc++) begin
      in_valid  = (sent < 9) && pat_in[cyc % 16];
      in_data   = 32'hA000_0000 + 32'(sent);
      out_ready = pat_out[cyc % 16];
      check_eq("wrap_count", 64'(count), 64'(model_q.size()));
      check_eq("wrap_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) check_eq("wrap_head", 64'(out_data), 64'(model_q[0]));
      wf = in_valid && (model_q.size() < 4);
      rf = out_ready && (model_q.size() != 0);
      step();
      if (rf) begin
        void'(model_q.pop_front());
        got++;
      end
      if (wf) begin
        model_q.push_back(32'hA000_0000 + 32'(sent));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("wrap_delivered", 64'(got), 64'd9);
    check_eq("wrap_xfer", xfer_cnt, 64'd27);

    // xfer_cnt wrap from all-ones
    force dut.xfer_cnt_d = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.xfer_cnt_d;
    check_eq("xfer_preload", xfer_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    push(32'h5555_AAAA);
    pop_check("xfer_wrap_word", 32'h5555_AAAA);
    check_eq("xfer_wrap", xfer_cnt, 64'd0);

    // Flush with concurrent read and write
    push(32'hB000_0000);
    push(32'hB000_0001);
    push(32'hB000_0002);
    check_eq("flush_pre_count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hBAD0_BAD0;
    out_ready = 1'b1;
    check_eq("flush_cyc_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_cyc_out_valid", 64'(out_valid), 64'd1);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_xfer", xfer_cnt, 64'd0);
    push(32'hC000_0000);
    pop_check("post_flush", 32'hC000_0000);
    check_eq("post_flush_count", 64'(count), 64'd0);
    check_eq("post_flush_xfer", xfer_cnt, 64'd1);

    // Asynchronous reset between edges
    push(32'hD000_0000);
    push(32'hD000_0001);
    check_eq("prerst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_in_ready", 64'(in_ready), 64'd0);
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_xfer", xfer_cnt, 64'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("arst_rel_in_ready", 64'(in_ready), 64'd1);
    check_eq("arst_rel_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'hD000_0002;
    step();
    in_valid = 1'b0;
    check_eq("arst_rel_count", 64'(count), 64'd1);
    pop_check("arst_first", 32'hD000_0002);
    check_eq("arst_final_xfer", xfer_cnt, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
